mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port `mem` block between the `tarhi` core (port 0) and a second bus master such as a loader or debug engine (port 1). It sits between the masters and `mem`, drives `mem_addr`, `mem_write` and `mem_dout`, and returns `mem_din` to the owner of each read. Arbitration is round-robin by default. Each request gets a registered grant and a tagged read-valid.

---
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing a single-port mem between two bus masters, with a
// tagged read-return pipe. Define MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties).
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_dout,
    input  logic [DATA_W-1:0] mem_din
);
    typedef enum logic {IDLE, ISSUE} state_e;
    typedef struct packed {
        logic vld;
        logic id;
    } rtag_t;

    state_e              state_q, state_d;
    logic                win_id_q, win_id_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_write_q, mem_write_d;
    logic [DATA_W-1:0]   mem_dout_q, mem_dout_d;
    rtag_t [READ_LAT-1:0] rd_pipe_q;
    logic                pick;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign pick = ~m0_req;
`else
    logic last_q, last_d;
    // On a tie the port not granted most recently wins.
    assign pick = (m0_req && m1_req) ? ~last_q : ~m0_req;
`endif

    always_comb begin
        state_d     = state_q;
        win_id_d    = win_id_q;
        mem_addr_d  = mem_addr_q;
        mem_dout_d  = mem_dout_q;
        mem_write_d = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    win_id_d    = pick;
                    mem_addr_d  = pick ? m1_addr  : m0_addr;
                    mem_dout_d  = pick ? m1_wdata : m0_wdata;
                    mem_write_d = pick ? m1_write : m0_write;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    last_d      = pick;
`endif
                    state_d     = ISSUE;
                end
            end
            ISSUE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            win_id_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_write_q <= 1'b0;
            mem_dout_q  <= '0;
            rd_pipe_q   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            win_id_q    <= win_id_d;
            mem_addr_q  <= mem_addr_d;
            mem_write_q <= mem_write_d;
            mem_dout_q  <= mem_dout_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
            // mem_write_q is high only in ISSUE for writes, so it doubles as the op type.
            rd_pipe_q[0] <= '{vld: (state_q == ISSUE) && !mem_write_q, id: win_id_q};
            for (int i = 1; i < READ_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
        end
    end

    assign m0_gnt    = (state_q == ISSUE) && !win_id_q;
    assign m1_gnt    = (state_q == ISSUE) &&  win_id_q;
    assign m0_rvalid = rd_pipe_q[READ_LAT-1].vld && !rd_pipe_q[READ_LAT-1].id;
    assign m1_rvalid = rd_pipe_q[READ_LAT-1].vld &&  rd_pipe_q[READ_LAT-1].id;
    assign m0_rdata  = mem_din;
    assign m1_rdata  = mem_din;
    assign mem_addr  = mem_addr_q;
    assign mem_write = mem_write_q;
    assign mem_dout  = mem_dout_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 at READ_LAT=1, instance 1 at READ_LAT=3, each with a mem model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    logic        clk;
    logic        rst_n;
    logic        req    [2][2];
    logic        wr     [2][2];
    logic [23:0] addr   [2][2];
    logic [31:0] wdata  [2][2];
    logic        gnt    [2][2];
    logic        rvalid [2][2];
    logic [31:0] rdata  [2][2];
    logic [23:0] mem_addr  [2];
    logic        mem_write [2];
    logic [31:0] mem_dout  [2];
    logic [31:0] mem_din   [2];

    logic        pl_we;
    int          pl_inst;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;

    typedef struct {
        int          inst;
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sbq[$];

    int cyc;
    int checks;
    int errs;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] marr [0:255];
        logic [31:0] rp   [0:3];
        always @(posedge clk) begin
            if (pl_we && pl_inst == g) marr[pl_addr] <= pl_data;
            else if (mem_write[g]) marr[mem_addr[g][7:0]] <= mem_dout[g];
            rp[0] <= marr[mem_addr[g][7:0]];
            for (int j = 1; j < 4; j++) rp[j] <= rp[j-1];
        end
        assign mem_din[g] = rp[LAT-1];

        mem_arbiter #(.ADDR_W(24), .DATA_W(32), .READ_LAT(LAT)) u_dut (
            .clk(clk), .reset(rst_n),
            .m0_req(req[g][0]), .m0_write(wr[g][0]), .m0_addr(addr[g][0]), .m0_wdata(wdata[g][0]),
            .m0_gnt(gnt[g][0]), .m0_rvalid(rvalid[g][0]), .m0_rdata(rdata[g][0]),
            .m1_req(req[g][1]), .m1_write(wr[g][1]), .m1_addr(addr[g][1]), .m1_wdata(wdata[g][1]),
            .m1_gnt(gnt[g][1]), .m1_rvalid(rvalid[g][1]), .m1_rdata(rdata[g][1]),
            .mem_addr(mem_addr[g]), .mem_write(mem_write[g]), .mem_dout(mem_dout[g]),
            .mem_din(mem_din[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int i, input int p, input logic [31:0] d, input int due);
        exp_t e;
        e.inst = i; e.port = p; e.data = d; e.due = due;
        sbq.push_back(e);
    endtask

    task automatic drive(input int i, input int p, input logic w, input logic [23:0] a,
                         input logic [31:0] d);
        req[i][p] = 1'b1; wr[i][p] = w; addr[i][p] = a; wdata[i][p] = d;
    endtask

    // Advance one cycle, then retire any rvalid against the scoreboard.
    task automatic step();
        int   idx;
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rvalid[i][0] || rvalid[i][1]) begin
                idx = -1;
                for (int j = 0; j < sbq.size(); j++) if (idx < 0 && sbq[j].inst == i) idx = j;
                if (idx < 0) begin
                    chk($sformatf("rvalid_spurious_i%0d", i), {62'd0, rvalid[i][1], rvalid[i][0]}, 64'd0);
                end else begin
                    e = sbq[idx];
                    sbq.delete(idx);
                    chk($sformatf("rvalid_port_i%0d", i), {62'd0, rvalid[i][1], rvalid[i][0]},
                        (e.port == 1) ? 64'd2 : 64'd1);
                    chk($sformatf("rdata_i%0d", i), {32'd0, rdata[i][e.port]}, {32'd0, e.data});
                    chk($sformatf("rvalid_cycle_i%0d", i), 64'(cyc), 64'(e.due));
                end
            end
        end
        for (int j = sbq.size() - 1; j >= 0; j--) begin
            if (sbq[j].due <= cyc) begin
                e = sbq[j];
                sbq.delete(j);
                chk($sformatf("rvalid_missing_i%0d_p%0d", e.inst, e.port), {63'd0, rvalid[e.inst][e.port]}, 64'd1);
            end
        end
    endtask

    function automatic logic [1:0] gv(input int i);
        return {gnt[i][1], gnt[i][0]};
    endfunction

    task automatic chk_idle_outputs(input string tag, input int i);
        chk({tag, "_mem_addr"},  {40'd0, mem_addr[i]}, 64'd0);
        chk({tag, "_mem_write"}, {63'd0, mem_write[i]}, 64'd0);
        chk({tag, "_mem_dout"},  {32'd0, mem_dout[i]}, 64'd0);
        chk({tag, "_gnt"},       {62'd0, gv(i)}, 64'd0);
        chk({tag, "_rvalid"},    {62'd0, rvalid[i][1], rvalid[i][0]}, 64'd0);
    endtask

    initial begin
        int k;
        logic [1:0] exp_g;
        cyc = 0; checks = 0; errs = 0;
        rst_n = 1'b0; pl_we = 1'b0; pl_inst = 0; pl_addr = '0; pl_data = '0;
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++) begin
                req[i][p] = 1'b0; wr[i][p] = 1'b0; addr[i][p] = '0; wdata[i][p] = '0;
            end

        // Reset state
        step(); step();
        chk_idle_outputs("rst_i0", 0);
        chk_idle_outputs("rst_i1", 1);
        rst_n = 1'b1;

        // Preload memories
        pl_we = 1'b1; pl_inst = 0; pl_addr = 8'h10; pl_data = 32'hDEADBEEF; step();
        pl_inst = 1; pl_addr = 8'h30; pl_data = 32'hAAAA1111; step();
        pl_addr = 8'h40; pl_data = 32'hBBBB2222; step();
        pl_we = 1'b0;

        // Single read, READ_LAT=1
        k = cyc;
        drive(0, 0, 1'b0, 24'h000010, 32'h0);
        push(0, 0, 32'hDEADBEEF, k + 2);
        step();
        chk("single_gnt", {62'd0, gv(0)}, 64'd1);
        chk("single_mem_addr", {40'd0, mem_addr[0]}, 64'h10);
        chk("single_mem_write", {63'd0, mem_write[0]}, 64'd0);
        req[0][0] = 1'b0;
        step();
        chk("single_gnt_pulse", {62'd0, gv(0)}, 64'd0);
        step(); step();

        // Write then read on port 1
        drive(0, 1, 1'b1, 24'h000020, 32'h12345678);
        step();
        chk("wr_gnt", {62'd0, gv(0)}, 64'd2);
        chk("wr_mem_write", {63'd0, mem_write[0]}, 64'd1);
        chk("wr_mem_addr", {40'd0, mem_addr[0]}, 64'h20);
        chk("wr_mem_dout", {32'd0, mem_dout[0]}, 64'h12345678);
        req[0][1] = 1'b0;
        step();
        chk("wr_mem_write_drop", {63'd0, mem_write[0]}, 64'd0);
        k = cyc;
        drive(0, 1, 1'b0, 24'h000020, 32'h0);
        push(0, 1, 32'h12345678, k + 2);
        step();
        chk("rd20_gnt", {62'd0, gv(0)}, 64'd2);
        req[0][1] = 1'b0;
        step(); step();

        // Tie: both hold req continuously
        drive(0, 0, 1'b1, 24'h000050, 32'h50505050);
        drive(0, 1, 1'b1, 24'h000051, 32'h51515151);
        for (int j = 0; j < 4; j++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (j % 2 == 1) ? 2'b10 : 2'b01;
`endif
            step();
            chk($sformatf("tie_gnt_%0d", j), {62'd0, gv(0)}, {62'd0, exp_g});
            step();
            chk($sformatf("tie_gap_%0d", j), {62'd0, gv(0)}, 64'd0);
        end
        req[0][0] = 1'b0; req[0][1] = 1'b0;
        step();

        // READ_LAT=3: m0 read then m1 read back-to-back
        k = cyc;
        drive(1, 0, 1'b0, 24'h000030, 32'h0);
        push(1, 0, 32'hAAAA1111, k + 4);
        step();
        chk("lat3_gnt0", {62'd0, gv(1)}, 64'd1);
        req[1][0] = 1'b0;
        drive(1, 1, 1'b0, 24'h000040, 32'h0);
        push(1, 1, 32'hBBBB2222, k + 6);
        step();
        chk("lat3_gap", {62'd0, gv(1)}, 64'd0);
        step();
        chk("lat3_gnt1", {62'd0, gv(1)}, 64'd2);
        req[1][1] = 1'b0;
        for (int j = 0; j < 4; j++) step();

        // Reset mid-read on instance 1; instance 0 grants m0 so its pointer moves off 1
        k = cyc;
        drive(1, 0, 1'b0, 24'h000030, 32'h0);
        drive(0, 0, 1'b1, 24'h000060, 32'h60606060);
        push(1, 0, 32'hAAAA1111, k + 4);
        step();
        chk("rstmid_gnt", {62'd0, gv(1)}, 64'd1);
        req[1][0] = 1'b0; req[0][0] = 1'b0;
        step();
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk_idle_outputs("rstmid_i0", 0);
        chk_idle_outputs("rstmid_i1", 1);
        for (int j = 0; j < 4; j++) begin
            step();
            chk($sformatf("rstlow_rvalid_%0d", j), {62'd0, rvalid[1][1], rvalid[1][0]}, 64'd0);
        end
        rst_n = 1'b1;
        step();

        // First tie after reset goes to port 0
        drive(0, 0, 1'b1, 24'h000070, 32'h70707070);
        drive(0, 1, 1'b1, 24'h000071, 32'h71717171);
        step();
        chk("post_rst_tie", {62'd0, gv(0)}, 64'd1);
        req[0][0] = 1'b0; req[0][1] = 1'b0;
        for (int j = 0; j < 6; j++) step();
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule
